mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_port_arbiter_rr_pick4.sv | 25 ++
 rtl/mem_port_arbiter.sv | 94 +++++++++
 tb/tb_mem_port_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-way memory port arbiter.
// Requester indices match the select encoding of the port mux.
package mem_arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01
    } state_t;

    localparam logic [IDX_W-1:0] REQ_IF  = 2'd0;
    localparam logic [IDX_W-1:0] REQ_DM  = 2'd1;
    localparam logic [IDX_W-1:0] REQ_RF  = 2'd2;
    localparam logic [IDX_W-1:0] REQ_DBG = 2'd3;

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick4.sv
// Combinational round-robin winner select: the search starts just after the
// last releaser and wraps, so the releaser itself has lowest priority.
module rr_pick4
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk from lowest to highest priority so the highest set candidate wins.
    always_comb begin
        valid = |req;
        idx   = last;
        cand  = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = last + IDX_W'(k);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port: one transaction at a time,
// with bounded locked bursts and registered grant/select/done outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  lock,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic [IDX_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             busy
);

    state_t           st_q, st_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NREQ-1:0]  done_q, done_d;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             burst_more;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    assign burst_more = lock[owner_q] & req[owner_q] &
                        (cnt_q < CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q    <= ST_IDLE;
            owner_q <= REQ_IF;
            last_q  <= REQ_DBG;
            cnt_q   <= '0;
            done_q  <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        case (st_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    st_d    = ST_BUSY;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    done_d = onehot(owner_q);
                    // Burst continues straight into the next transaction.
                    if (burst_more) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        st_d   = ST_IDLE;
                        last_d = owner_q;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // Owner register doubles as the mux select so it stays put while idle.
    assign busy    = (st_q == ST_BUSY);
    assign mem_req = busy;
    assign sel     = owner_q;
    assign gnt     = busy ? onehot(owner_q) : '0;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a transaction-level model predicts per-cycle outputs,
// a monitor pops and compares them one cycle at a time.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] req = 4'b1111;
    logic [3:0] lock = 4'b0000;
    logic       mem_ack = 1'b0;
    logic       mem_req;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       mreq;
        logic       busy;
        logic [3:0] done;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter #(.MAX_BURST(MAXB), .CNT_W(3)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .lock    (lock),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .sel     (sel),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Reference: who owns the port, who released last, how many burst beats used.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_last  = 3;
    int m_beats = 0;

    always @(posedge clk or negedge resetn) begin
        exp_t e;
        logic [3:0] d;
        d = 4'b0;
        if (!resetn) begin
            m_busy = 0; m_owner = 0; m_last = 3; m_beats = 0;
        end else if (!m_busy) begin
            for (int step = 1; step <= 4; step++) begin
                if (req[(m_last + step) % 4]) begin
                    m_owner = (m_last + step) % 4;
                    m_busy  = 1;
                    m_beats = 1;
                    break;
                end
            end
        end else if (mem_ack) begin
            d[m_owner] = 1'b1;
            if (lock[m_owner] && req[m_owner] && m_beats < MAXB) begin
                m_beats++;
            end else begin
                m_last = m_owner;
                m_busy = 0;
            end
        end
        if (clk === 1'b1) begin
            e.gnt  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            e.sel  = 2'(m_owner);
            e.mreq = m_busy;
            e.busy = m_busy;
            e.done = d;
            sb.push_back(e);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (gnt !== e.gnt || sel !== e.sel || mem_req !== e.mreq ||
                busy !== e.busy || done !== e.done) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t got gnt=%b sel=%0d mreq=%b busy=%b done=%b want gnt=%b sel=%0d mreq=%b busy=%b done=%b",
                         $time, gnt, sel, mem_req, busy, done,
                         e.gnt, e.sel, e.mreq, e.busy, e.done);
            end
        end
    end

    // mode 0: req all high, ack on grant; 1: burst scenario; 2: random
    task automatic run(input int mode, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            case (mode)
                0: begin req = 4'b1111; lock = 4'b0000; mem_ack = mem_req; end
                1: begin req = 4'b0011; lock = 4'b0010; mem_ack = mem_req; end
                default: begin
                    for (int i = 0; i < 4; i++) begin
                        if (done[i] && ($urandom % 2 == 0)) req[i] = 1'b0;
                        else if (!req[i] && ($urandom % 4 == 0)) req[i] = 1'b1;
                    end
                    lock    = 4'($urandom);
                    mem_ack = ($urandom % 3 == 0);
                end
            endcase
        end
    endtask

    task automatic reset_mid_op();
        int w;
        w = 0;
        while (!mem_req && w < 50) begin
            run(2, 1);
            w++;
        end
        total++;
        if (!mem_req) begin
            bad++;
            $display("FAIL wait_busy got mem_req=%b want 1 within 50 cycles", mem_req);
        end
        @(negedge clk);
        mem_ack = 1'b1;
        resetn  = 1'b0;
        #1;
        total++;
        if (gnt !== 4'b0 || sel !== 2'd0 || mem_req !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin
            bad++;
            $display("FAIL async_reset got gnt=%b sel=%0d mreq=%b busy=%b done=%b want all zero",
                     gnt, sel, mem_req, busy, done);
        end
        req = 4'b1111;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        run(0, 12);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (gnt !== 4'b0 || sel !== 2'd0 || mem_req !== 1'b0 || done !== 4'b0) begin
            bad++;
            $display("FAIL reset_state got gnt=%b sel=%0d mreq=%b done=%b want zeros",
                     gnt, sel, mem_req, done);
        end
        resetn = 1'b1;
        run(0, 20);
        run(1, 30);
        // stray acks with nothing requested
        @(negedge clk); req = 4'b0; lock = 4'b0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        mem_ack = 1'b0;
        req = 4'b0100;
        run(2, 1500);
        reset_mid_op();
        run(2, 500);
        reset_mid_op();
        run(2, 300);
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
